// File: rtl/frame_strobe_writer_if.sv
// rtl/frame_strobe_writer_if.sv - bitstream word stream handshake into the frame writer
interface frame_strobe_writer_if #(
  parameter int W = 32
);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_writer.sv
// rtl/frame_strobe_writer.sv - assembles one frame of row data and pulses the addressed FrameStrobe bit
module frame_strobe_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 4,
  parameter int NumRows         = 4
) (
  input  logic                                   UserCLK,
  input  logic                                   reset,
  frame_strobe_writer_if.slave                   s,
  output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   ConfigBusy,
  output logic [15:0]                            FrameCount,
  output logic                                   HeaderErr
);

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
  localparam int          RW          = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(NumRows - 1);

  typedef enum logic [2:0] {IDLE, HEADER, DATA, SKIP, STROBE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    col_q;
  logic [4:0]    frm_q;
  logic [RW-1:0] row_q;
  logic          accept;
  logic          take_hdr;
  logic          hdr_bad;
  logic          herr_clr;
  logic          row_wr;
  logic          row_adv;
  logic          hdr_ok;
  logic [7:0]    hdr_col;
  logic [4:0]    hdr_frm;
  int            strobe_idx;
  logic [NumColumns*MaxFramesPerCol-1:0] strobe_d;

  assign s.s_ready  = (state_q != STROBE);
  assign accept     = s.s_valid && (state_q != STROBE);
  assign ConfigBusy = (state_q != IDLE);
  assign hdr_col    = s.s_data[23:16];
  assign hdr_frm    = s.s_data[4:0];
  assign hdr_ok     = (int'(hdr_col) < NumColumns) && (int'(hdr_frm) < MaxFramesPerCol);
  assign strobe_idx = int'(col_q) * MaxFramesPerCol + int'(frm_q);

  always_comb begin
    state_d  = state_q;
    take_hdr = 1'b0;
    hdr_bad  = 1'b0;
    herr_clr = 1'b0;
    row_wr   = 1'b0;
    row_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && s.s_data == SYNC_WORD) begin
          state_d  = HEADER;
          herr_clr = 1'b1;
        end
      end
      HEADER: begin
        if (accept) begin
          if (s.s_data == DESYNC_WORD) begin
            state_d = IDLE;
          end else if (s.s_data[31:28] == 4'hA) begin
            if (hdr_ok) begin
              take_hdr = 1'b1;
              state_d  = DATA;
            end else begin
              hdr_bad = 1'b1;
              state_d = SKIP;
            end
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          row_wr  = 1'b1;
          row_adv = 1'b1;
          if (row_q == LAST_ROW) state_d = STROBE;
        end
      end
      SKIP: begin
        if (accept) begin
          row_adv = 1'b1;
          if (row_q == LAST_ROW) state_d = HEADER;
        end
      end
      STROBE:  state_d = HEADER;
      default: state_d = IDLE;
    endcase
  end

  // The strobe is registered from the next state so it is high exactly while in STROBE.
  always_comb begin
    strobe_d = '0;
    if (state_d == STROBE) begin
      for (int i = 0; i < NumColumns * MaxFramesPerCol; i++) begin
        strobe_d[i] = (i == strobe_idx);
      end
    end
  end

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      frm_q       <= '0;
      row_q       <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      FrameCount  <= '0;
      HeaderErr   <= 1'b0;
    end else begin
      FrameStrobe <= strobe_d;
      if (take_hdr) begin
        col_q <= hdr_col;
        frm_q <= hdr_frm;
      end
      if (state_q == HEADER) begin
        row_q <= '0;
      end else if (row_adv) begin
        row_q <= row_q + 1'b1;
      end
      if (row_wr) begin
        FrameData[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] <= s.s_data;
      end
      if (herr_clr) begin
        HeaderErr <= 1'b0;
      end else if (hdr_bad) begin
        HeaderErr <= 1'b1;
      end
      if (state_q == STROBE) begin
        FrameCount <= FrameCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_strobe_writer.sv
// tb/tb_frame_strobe_writer.sv - randomized scoreboard bench for frame_strobe_writer
module tb_frame_strobe_writer;

  localparam int BITS  = 32;
  localparam int FRMS  = 20;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  typedef struct {
    logic [COLS*FRMS-1:0] strobe;
    logic [ROWS*BITS-1:0] data;
    logic [15:0]          cnt;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [ROWS*BITS-1:0] frame_data;
  logic [COLS*FRMS-1:0] frame_strobe;
  logic                 config_busy;
  logic [15:0]          frame_count;
  logic                 header_err;

  frame_strobe_writer_if bus ();

  frame_strobe_writer #(
    .FrameBitsPerRow(BITS), .MaxFramesPerCol(FRMS), .NumColumns(COLS), .NumRows(ROWS)
  ) dut (
    .UserCLK    (clk),
    .reset      (rst),
    .s          (bus),
    .FrameData  (frame_data),
    .FrameStrobe(frame_strobe),
    .ConfigBusy (config_busy),
    .FrameCount (frame_count),
    .HeaderErr  (header_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: protocol-level view of the word stream
  logic                 m_synced;
  logic                 m_herr;
  int                   m_mode;      // 0 header, 1 data, 2 skip
  int                   m_cnt;
  int                   m_col;
  int                   m_frm;
  int                   m_frames;
  logic [ROWS*BITS-1:0] m_fd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_synced = 1'b0;
    m_herr   = 1'b0;
    m_mode   = 0;
    m_cnt    = 0;
    m_frames = 0;
    m_fd     = '0;
  endtask

  task automatic model_word(input logic [31:0] w);
    exp_t e;
    if (!m_synced) begin
      if (w == SYNC) begin
        m_synced = 1'b1;
        m_herr   = 1'b0;
        m_mode   = 0;
      end
    end else if (m_mode == 0) begin
      if (w == DESYNC) begin
        m_synced = 1'b0;
      end else if (w[31:28] == 4'hA) begin
        m_cnt = 0;
        if (int'(w[23:16]) < COLS && int'(w[4:0]) < FRMS) begin
          m_col  = int'(w[23:16]);
          m_frm  = int'(w[4:0]);
          m_mode = 1;
        end else begin
          m_herr = 1'b1;
          m_mode = 2;
        end
      end else begin
        m_herr = 1'b1;
      end
    end else if (m_mode == 1) begin
      m_fd[m_cnt*BITS +: BITS] = w;
      m_cnt++;
      if (m_cnt == ROWS) begin
        e.strobe = '0;
        e.strobe[m_col*FRMS + m_frm] = 1'b1;
        e.data = m_fd;
        e.cnt  = 16'(m_frames);
        exp_q.push_back(e);
        m_frames++;
        m_mode = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == ROWS) m_mode = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [31:0] w, input int maxgap);
    int gap;
    int tries;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    tries = 0;
    while (!bus.s_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    model_word(w);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("busy", 128'(config_busy), 128'(m_synced));
    chk("header_err", 128'(header_err), 128'(m_herr));
    chk("frame_data", 128'(frame_data), 128'(m_fd));
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input int maxgap);
    send(hdr, maxgap);
    for (int i = 0; i < ROWS; i++) send(base * 32'(i + 1), maxgap);
  endtask

  // Monitor: every strobe the DUT presents must match the next expected frame
  always @(negedge clk) begin
    exp_t e;
    if (!rst && frame_strobe != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%h expected=0", frame_strobe);
      end else begin
        e = exp_q.pop_front();
        chk("strobe", 128'(frame_strobe), 128'(e.strobe));
        chk("strobe_data", 128'(frame_data), 128'(e.data));
        chk("strobe_count", 128'(frame_count), 128'(e.cnt));
        chk("strobe_ready", 128'(bus.s_ready), 128'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int r;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_data", 128'(frame_data), 128'(0));
    chk("rst_strobe", 128'(frame_strobe), 128'(0));
    chk("rst_count", 128'(frame_count), 128'(0));
    chk("rst_herr", 128'(header_err), 128'(0));
    chk("rst_busy", 128'(config_busy), 128'(0));
    chk("rst_ready", 128'(bus.s_ready), 128'(1));
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: column 1, frame 3 -> strobe bit 23
    send(SYNC, 0);
    send_frame(32'hA001_0003, 32'h1111_1111, 0);
    repeat (2) @(negedge clk);
    chk("count_after_first", 128'(frame_count), 128'(1));
    chk("first_frame_data", 128'(frame_data),
        128'({32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}));

    // Out-of-range column, then a valid header
    send_frame(32'hA004_0000, 32'h0505_0505, 0);
    send_frame(32'hA002_0005, 32'h0101_0101, 0);

    // Frame index boundary: 20 rejected, 19 accepted
    send_frame(32'hA000_0014, 32'h0707_0707, 0);
    send_frame(32'hA000_0013, 32'h0909_0909, 0);

    // Desync value as data, then as a header
    send(32'hA003_0001, 0);
    send(32'h0000_0005, 0);
    send(DESYNC, 0);
    send(32'h0000_0007, 0);
    send(32'h0000_0008, 0);
    send(DESYNC, 0);
    send_frame(32'hA000_0000, 32'h0F0F_0F0F, 0);

    // Same frame with stalls
    send(SYNC, 2);
    send_frame(32'hA001_0003, 32'h1111_1111, 3);

    // Asynchronous reset mid-frame
    send(32'hA002_0002, 0);
    send(32'hDEAD_0001, 0);
    send(32'hDEAD_0002, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_data", 128'(frame_data), 128'(0));
    chk("async_strobe", 128'(frame_strobe), 128'(0));
    chk("async_count", 128'(frame_count), 128'(0));
    chk("async_busy", 128'(config_busy), 128'(0));
    chk("async_herr", 128'(header_err), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'hDEAD_0003, 0);
    send(32'hDEAD_0004, 0);
    send_frame(32'hA000_0001, 32'h2222_2222, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (!m_synced) begin
        w = (r < 50) ? SYNC : $urandom;
      end else if (m_mode == 0) begin
        if (r < 4)       w = DESYNC;
        else if (r < 12) w = {4'($urandom_range(0, 9)), 28'($urandom)};
        else             w = {4'hA, 4'h0, 8'($urandom_range(0, 5)), 11'($urandom), 5'($urandom_range(0, 23))};
      end else begin
        if (r < 5)       w = SYNC;
        else if (r < 10) w = DESYNC;
        else             w = $urandom;
      end
      send(w, (r < 30) ? 3 : 0);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("final_count", 128'(frame_count), 128'(16'(m_frames)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
